// File: rtl/seq_checker.sv
// Receive-side integrity checker for the 000->001->010->100->110 cyclic code.
// Hunts for alignment, locks after LOCK_CNT correct samples, then flags and counts mismatches.
module seq_checker #(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       state_in,
  output logic             locked,
  output logic             err,
  output logic             illegal,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       expected
);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  localparam logic [3:0] LockCnt = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       exp_q, exp_d;
  logic             err_q, err_d;
  logic             illegal_q, illegal_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] err_cnt_inc;
  logic [2:0]       next_in;
  logic             legal_in;

  always_comb begin
    next_in  = 3'b000;
    legal_in = 1'b1;
    unique case (state_in)
      3'b000:  next_in = 3'b001;
      3'b001:  next_in = 3'b010;
      3'b010:  next_in = 3'b100;
      3'b100:  next_in = 3'b110;
      3'b110:  next_in = 3'b000;
      default: legal_in = 1'b0;
    endcase
  end

  assign err_cnt_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    err_d     = 1'b0;
    illegal_d = 1'b0;
    err_cnt_d = err_cnt_q;
    if (in_valid) begin
      unique case (state_q)
        StHunt: begin
          if (legal_in) begin
            exp_d   = next_in;
            cnt_d   = 4'd1;
            state_d = (LockCnt == 4'd1) ? StLocked : StVerify;
          end else begin
            illegal_d = 1'b1;
          end
        end
        StVerify: begin
          if (!legal_in) begin
            illegal_d = 1'b1;
            cnt_d     = 4'd0;
            state_d   = StHunt;
          end else if (state_in == exp_q) begin
            exp_d = next_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 >= LockCnt) state_d = StLocked;
          end else begin
            // Realign on the new sample and restart the run.
            exp_d = next_in;
            cnt_d = 4'd1;
          end
        end
        StLocked: begin
          if (!legal_in) begin
            err_d     = 1'b1;
            illegal_d = 1'b1;
            err_cnt_d = err_cnt_inc;
            cnt_d     = 4'd0;
            state_d   = StHunt;
          end else if (state_in == exp_q) begin
            exp_d = next_in;
          end else begin
            err_d     = 1'b1;
            err_cnt_d = err_cnt_inc;
            exp_d     = next_in;
            cnt_d     = 4'd1;
            state_d   = StVerify;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StHunt;
      cnt_q     <= 4'd0;
      exp_q     <= 3'b000;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked   = (state_q == StLocked);
  assign err      = err_q;
  assign illegal  = illegal_q;
  assign err_cnt  = err_cnt_q;
  assign expected = exp_q;

endmodule
